// File: rtl/prize_pkg.sv
// +------------------------------------------------------------------+
// | prize_pkg: prize map constants and collision FSM state encoding   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package prize_pkg;

   localparam logic [2:0] FREE        = 3'd0;
   localparam logic [2:0] REGU        = 3'd1;
   localparam int         TILE_SHIFT  = 6;
   localparam int         TILE_IDX_W  = 4;
   localparam int         NUM_OF_ROWS = 7;
   localparam int         NUM_OF_COLS = 10;

   typedef enum logic [1:0] {
      ARMED    = 2'd0,
      PULSE    = 2'd1,
      COOLDOWN = 2'd2
   } collision_state_t;

endpackage

`default_nettype wire

// File: rtl/prize_collision_manager_frame_holdoff_counter.sv
// +------------------------------------------------------------------+
// | frame_holdoff_counter: frame-granular down counter with zero flag |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module frame_holdoff_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic             zero,
   output logic             expire
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_value;
      end else if (dec && (r_count != '0)) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign zero   = (r_count == '0);
   // High on the decrement that lands on zero, so the owner can leave in the same edge.
   assign expire = dec && !load && (r_count == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/prize_collision_manager.sv
// +------------------------------------------------------------------+
// | prize_collision_manager: qualifies Bumpy/prize overlaps, emits one |
// | frame-aligned pulse per hit, tracks hit tile and collected count   |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module prize_collision_manager
   import prize_pkg::*;
#(
   parameter int TOTAL_PRIZES   = 9,
   parameter int HOLDOFF_FRAMES = 2,
   parameter int CNT_W          = 8
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             startOfFrame,
   input  logic [10:0]      pixelX,
   input  logic [10:0]      pixelY,
   input  logic             bumpy_draw_request,
   input  logic             prize_draw_request,
   input  logic [2:0]       prize_type,
   output logic             prize_collision,
   output logic [3:0]       collision_tile_col,
   output logic [3:0]       collision_tile_row,
   output logic [CNT_W-1:0] prizes_collected,
   output logic             all_collected
);

   localparam logic [CNT_W-1:0] TOTAL_CNT = CNT_W'(TOTAL_PRIZES);
   localparam logic [3:0]       HOLD_LOAD = 4'(HOLDOFF_FRAMES);

   collision_state_t r_state, w_next;
   logic             w_overlap, w_latch, w_load;
   logic             w_hold_zero, w_hold_expire;
   logic             r_hit_pend, r_pulse, r_all;
   logic [3:0]       r_col, r_row;
   logic [CNT_W-1:0] r_count;
   logic             unused_pixel_bits;

   assign w_overlap = bumpy_draw_request & prize_draw_request & (prize_type != FREE);
   assign unused_pixel_bits = ^{pixelX[10], pixelX[5:0], pixelY[10], pixelY[5:0]};

   frame_holdoff_counter #(.WIDTH(4)) u_holdoff (
      .clk        (clk),
      .resetN     (resetN),
      .load       (w_load),
      .load_value (HOLD_LOAD),
      .dec        (startOfFrame && (r_state == COOLDOWN)),
      .zero       (w_hold_zero),
      .expire     (w_hold_expire)
   );

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) r_state <= ARMED;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_latch = 1'b0;
      w_load  = 1'b0;
      case (r_state)
         // The strobe closes the previous frame before any overlap is considered.
         ARMED: begin
            if (startOfFrame && r_hit_pend)    w_next  = PULSE;
            else if (w_overlap && !r_hit_pend) w_latch = 1'b1;
         end
         PULSE: begin
            w_next = COOLDOWN;
            w_load = 1'b1;
         end
         COOLDOWN: begin
            if (w_hold_expire || w_hold_zero) w_next = ARMED;
         end
         default: w_next = ARMED;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_hit_pend <= 1'b0;
         r_pulse    <= 1'b0;
         r_col      <= '0;
         r_row      <= '0;
         r_count    <= '0;
         r_all      <= 1'b0;
      end else begin
         r_pulse <= (w_next == PULSE);
         if (w_latch) begin
            r_hit_pend <= 1'b1;
            r_col      <= pixelX[TILE_SHIFT +: TILE_IDX_W];
            r_row      <= pixelY[TILE_SHIFT +: TILE_IDX_W];
         end else if (r_state == PULSE) begin
            r_hit_pend <= 1'b0;
         end
         if ((r_state == PULSE) && (r_count != '1)) r_count <= r_count + CNT_W'(1);
         r_all <= r_all | (r_count >= TOTAL_CNT);
      end
   end

   assign prize_collision    = r_pulse;
   assign collision_tile_col = r_col;
   assign collision_tile_row = r_row;
   assign prizes_collected   = r_count;
   assign all_collected      = r_all;

endmodule

`default_nettype wire

// File: tb/tb_prize_collision_manager.sv
// +------------------------------------------------------------------+
// | tb_prize_collision_manager: directed bench with frame-level model |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_prize_collision_manager;

   localparam int TOTAL = 9;
   localparam int HOLD  = 2;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        startOfFrame = 1'b0;
   logic [10:0] pixelX = '0;
   logic [10:0] pixelY = '0;
   logic        bumpy = 1'b0;
   logic        prize = 1'b0;
   logic [2:0]  ptype = '0;
   logic        prize_collision, all_collected;
   logic [3:0]  tile_col, tile_row;
   logic [7:0]  prizes_collected;

   int n_cmp = 0;
   int n_fail = 0;
   int pulses = 0;
   int p0;

   prize_collision_manager #(
      .TOTAL_PRIZES(TOTAL), .HOLDOFF_FRAMES(HOLD), .CNT_W(8)
   ) dut (
      .clk                (clk),
      .resetN             (resetN),
      .startOfFrame       (startOfFrame),
      .pixelX             (pixelX),
      .pixelY             (pixelY),
      .bumpy_draw_request (bumpy),
      .prize_draw_request (prize),
      .prize_type         (ptype),
      .prize_collision    (prize_collision),
      .collision_tile_col (tile_col),
      .collision_tile_row (tile_row),
      .prizes_collected   (prizes_collected),
      .all_collected      (all_collected)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a hit is remembered until the next frame start, turns into one pulse,
   // then the following HOLD frame starts are skipped before hits count again.
   bit m_pend, m_ovl;
   int m_frames_left;
   int e_pulse, e_col, e_row, e_cnt, e_all;

   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         m_pend = 0; m_frames_left = 0;
         e_pulse = 0; e_col = 0; e_row = 0; e_cnt = 0; e_all = 0;
      end else begin
         m_ovl = bumpy && prize && (ptype != 3'd0);
         if (e_cnt >= TOTAL) e_all = 1;
         if (e_pulse == 1) begin
            e_pulse = 0;
            e_cnt = (e_cnt == 255) ? 255 : e_cnt + 1;
            m_pend = 0;
            m_frames_left = HOLD;
         end else if (m_frames_left > 0) begin
            if (startOfFrame) m_frames_left = m_frames_left - 1;
         end else if (startOfFrame && m_pend) begin
            e_pulse = 1;
         end else if (m_ovl && !m_pend) begin
            m_pend = 1;
            e_col = int'(pixelX) / 64 % 16;
            e_row = int'(pixelY) / 64 % 16;
         end
      end
   end

   always @(negedge clk) begin
      chk("pulse", prize_collision, e_pulse);
      chk("col", tile_col, e_col);
      chk("row", tile_row, e_row);
      chk("count", prizes_collected, e_cnt);
      chk("all", all_collected, e_all);
      if (prize_collision) pulses++;
   end

   task automatic step(input logic sof, input logic b, input logic p,
                       input logic [2:0] t, input int x, input int y);
      @(negedge clk);
      startOfFrame = sof; bumpy = b; prize = p; ptype = t;
      pixelX = 11'(x); pixelY = 11'(y);
      @(posedge clk);
      #1;
      startOfFrame = 0; bumpy = 0; prize = 0; ptype = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic sof();
      step(1, 0, 0, 0, 0, 0);
   endtask

   task automatic hit();
      step(0, 1, 1, 3'd1, 200, 130);
      sof();
      idle(1);
      sof();
      sof();
   endtask

   initial begin
      idle(3);
      @(negedge clk); #2 resetN = 1'b1;

      // Single hit at (200,130)
      step(0, 1, 1, 3'd1, 200, 130);
      idle(2);
      sof();
      chk("single_pulse", prize_collision, 1);
      chk("single_col", tile_col, 3);
      chk("single_row", tile_row, 2);
      idle(1);
      chk("single_pulse_end", prize_collision, 0);
      chk("single_count", prizes_collected, 1);

      // Asynchronous reset while cooling down
      #2 resetN = 1'b0;
      #1;
      chk("rst_pulse", prize_collision, 0);
      chk("rst_col", tile_col, 0);
      chk("rst_row", tile_row, 0);
      chk("rst_count", prizes_collected, 0);
      chk("rst_all", all_collected, 0);
      @(negedge clk); @(negedge clk); #2 resetN = 1'b1;
      p0 = pulses;
      repeat (3) begin sof(); idle(3); end
      chk("rst_no_pulse", pulses - p0, 0);

      // Two overlaps in one frame, first wins
      step(0, 1, 1, 3'd1, 200, 130);
      step(0, 1, 1, 3'd2, 520, 400);
      sof();
      chk("multi_pulse", prize_collision, 1);
      chk("multi_col", tile_col, 3);
      chk("multi_row", tile_row, 2);
      idle(1); sof(); sof();

      // FREE type and lone draw requests never count
      p0 = pulses;
      step(0, 1, 1, 3'd0, 300, 300);
      step(0, 1, 0, 3'd1, 300, 300);
      step(0, 0, 1, 3'd1, 300, 300);
      repeat (3) begin sof(); idle(2); end
      chk("free_no_pulse", pulses - p0, 0);

      // Overlap every frame with holdoff of 2 frames
      p0 = pulses;
      for (int i = 0; i < 9; i++) begin
         sof();
         step(0, 1, 1, 3'd1, 200, 130);
         idle(2);
      end
      chk("holdoff_pulses", pulses - p0, 3);

      // Strobe + overlap together: latched when idle, dropped when a hit is pending
      sof();
      step(1, 1, 1, 3'd1, 520, 400);
      step(1, 1, 1, 3'd1, 200, 130);
      chk("order_pulse", prize_collision, 1);
      chk("order_col", tile_col, 8);
      chk("order_row", tile_row, 6);
      idle(1); sof(); sof();
      chk("order_count", prizes_collected, 5);

      // Completion
      repeat (3) hit();
      step(0, 1, 1, 3'd1, 200, 130);
      sof();
      idle(1);
      chk("ninth_count", prizes_collected, 9);
      chk("ninth_all_early", all_collected, 0);
      idle(1);
      chk("ninth_all", all_collected, 1);
      sof(); sof();

      repeat (246) hit();
      chk("sat_reach", prizes_collected, 255);
      p0 = pulses;
      hit();
      chk("sat_pulse", pulses - p0, 1);
      chk("sat_hold", prizes_collected, 255);
      chk("sat_all", all_collected, 1);

      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
